// File: rtl/param_stream_ctrl.sv
// Streams DEPTH ROM words repeat_count times through a small FWFT buffer.
// ROM reads are credit-limited so the buffer can never overflow.
module param_stream_ctrl #(
  parameter int DATA_WIDTH   = 512,
  parameter int DEPTH        = 32,
  parameter int ADDR_WIDTH   = $clog2(DEPTH) + 1,
  parameter int REPEAT_WIDTH = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [REPEAT_WIDTH-1:0] repeat_count,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  output logic                    rom_ce,
  input  logic [DATA_WIDTH-1:0]   rom_q,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_out_valid,
  input  logic                    data_out_ready,
  output logic                    data_out_last
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [0:0]              state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [REPEAT_WIDTH-1:0] rep_q;
  logic [REPEAT_WIDTH-1:0] pass_cnt;
  logic [REPEAT_WIDTH-1:0] out_pass;
  logic                    v1, v2, l1, l2;

  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   last_mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [PW:0]             count;

  logic                    issue, push, pop;
  logic                    addr_last, final_beat;
  logic [PW+1:0]           credit;

  assign rom_ce         = 1'b1;
  assign rom_addr       = addr;
  assign busy           = (state == S_RUN);
  assign data_out_valid = (count != '0);
  assign data_out       = mem[rd_ptr];
  assign data_out_last  = data_out_valid & last_mem[rd_ptr];

  assign addr_last = (addr == ADDR_WIDTH'(DEPTH - 1));
  // Buffered plus in-flight words must leave room for one more read.
  assign credit = {1'b0, count} + (PW+2)'(v1) + (PW+2)'(v2);
  assign issue  = (state == S_RUN) && (pass_cnt != rep_q)
                  && (credit < (PW+2)'(FIFO_DEPTH));
  assign push   = v2;
  assign pop    = data_out_valid & data_out_ready;
  assign final_beat = pop && data_out_last
                      && (out_pass == rep_q - REPEAT_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      done     <= 1'b0;
      addr     <= '0;
      rep_q    <= '0;
      pass_cnt <= '0;
      out_pass <= '0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      l1       <= 1'b0;
      l2       <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_mem <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (repeat_count != '0) begin
              state    <= S_RUN;
              rep_q    <= repeat_count;
              addr     <= '0;
              pass_cnt <= '0;
              out_pass <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        default: begin
          if (final_beat) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
      endcase

      if (issue) begin
        if (addr_last) begin
          addr     <= '0;
          pass_cnt <= pass_cnt + REPEAT_WIDTH'(1);
        end else begin
          addr <= addr + ADDR_WIDTH'(1);
        end
      end

      v1 <= issue;
      l1 <= issue & addr_last;
      v2 <= v1;
      l2 <= l1;

      if (push) begin
        last_mem[wr_ptr] <= l2;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        if (data_out_last)
          out_pass <= out_pass + REPEAT_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Data storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= rom_q;
  end

endmodule

// File: tb/tb_param_stream_ctrl.sv
// Directed bench for param_stream_ctrl with DEPTH=4 and ROM[k]=0x100+k.
// The ROM model returns data two cycles after the address.
module tb_param_stream_ctrl;

  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int AW = 3;
  localparam int RW = 8;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [RW-1:0] repeat_count = '0;
  logic          busy, done;
  logic [AW-1:0] rom_addr;
  logic          rom_ce;
  logic [DW-1:0] rom_q = '0;
  logic [DW-1:0] q1 = '0;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          data_out_ready = 1'b0;
  logic          data_out_last;

  param_stream_ctrl #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .REPEAT_WIDTH(RW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .repeat_count(repeat_count), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_ce(rom_ce), .rom_q(rom_q),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .data_out_last(data_out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    q1    <= 16'h0100 + {13'd0, rom_addr};
    rom_q <= q1;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int addr_changes = 0;
  logic busy_at_done = 1'b0;
  logic toggle_en = 1'b0;
  logic [DW-1:0] beat_d[$];
  logic beat_l[$];
  int hs_cyc[$];

  task automatic clear_log();
    beat_d.delete();
    beat_l.delete();
    hs_cyc.delete();
    done_cnt = 0;
    addr_changes = 0;
  endtask

  task automatic step();
    logic [AW-1:0] a;
    logic hold_p;
    logic [DW-1:0] hold_d;
    logic hold_l;
    int idx;
    if (rst && data_out_valid && data_out_ready) begin
      beat_d.push_back(data_out);
      beat_l.push_back(data_out_last);
      hs_cyc.push_back(cyc);
    end
    hold_p = rst && data_out_valid && !data_out_ready;
    hold_d = data_out;
    hold_l = data_out_last;
    a = rom_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (rom_addr !== a) addr_changes++;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
    if (hold_p && rst) begin
      checks++;
      if (data_out_valid !== 1'b1 || data_out !== hold_d
          || data_out_last !== hold_l) begin
        failures++;
        $display("FAIL stall_hold got=%0h/%0b exp=%0h/%0b",
                 data_out, data_out_last, hold_d, hold_l);
      end
    end
    if (toggle_en) begin
      idx = cyc % 4;
      data_out_ready = (idx == 0) || (idx == 3);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rom_addr !== '0
        || data_out_valid !== 1'b0 || data_out_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=%b%b%0h%b%b exp=00000",
               busy, done, rom_addr, data_out_valid, data_out_last);
    end
    checks++;
    if (rom_ce !== 1'b1) begin
      failures++;
      $display("FAIL rom_ce got=%b exp=1", rom_ce);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    clear_log();
    repeat_count = 8'd2;
    data_out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (rom_addr !== 3'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL first_issue got=%0h/%b exp=0/1", rom_addr, busy);
    end
    step();
    step();
    checks++;
    if (data_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL valid_t3 got=%b exp=0", data_out_valid);
    end
    step();
    checks++;
    if (data_out_valid !== 1'b1 || data_out !== 16'h0100) begin
      failures++;
      $display("FAIL valid_t4 got=%b/%0h exp=1/100",
               data_out_valid, data_out);
    end
    wait_done(60);
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL basic_done got=%0d exp=1", done_cnt);
    end
    checks++;
    if (beat_d.size() != 8) begin
      failures++;
      $display("FAIL basic_count got=%0d exp=8", beat_d.size());
    end
    for (int i = 0; i < beat_d.size(); i++) begin
      checks++;
      if (beat_d[i] !== 16'h0100 + 16'(i % 4)
          || beat_l[i] !== (i % 4 == 3)) begin
        failures++;
        $display("FAIL basic_beat%0d got=%0h/%b exp=%0h/%b", i,
                 beat_d[i], beat_l[i], 16'h0100 + 16'(i % 4), (i % 4 == 3));
      end
    end
    if (hs_cyc.size() == 8) begin
      checks++;
      if (hs_cyc[7] - hs_cyc[0] != 7) begin
        failures++;
        $display("FAIL throughput got=%0d exp=7", hs_cyc[7] - hs_cyc[0]);
      end
      checks++;
      if (done_cyc != hs_cyc[7] + 1 || busy_at_done !== 1'b0) begin
        failures++;
        $display("FAIL done_timing got=%0d/%b exp=%0d/0",
                 done_cyc, busy_at_done, hs_cyc[7] + 1);
      end
    end
    step();
    checks++;
    if (done !== 1'b0 || done_cnt != 1) begin
      failures++;
      $display("FAIL done_pulse got=%b/%0d exp=0/1", done, done_cnt);
    end
  endtask

  task automatic test_toggle();
    clear_log();
    repeat_count = 8'd2;
    data_out_ready = 1'b1;
    toggle_en = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(100);
    toggle_en = 1'b0;
    data_out_ready = 1'b1;
    checks++;
    if (done_cnt != 1 || beat_d.size() != 8) begin
      failures++;
      $display("FAIL toggle_count got=%0d/%0d exp=1/8",
               done_cnt, beat_d.size());
    end
    for (int i = 0; i < beat_d.size(); i++) begin
      checks++;
      if (beat_d[i] !== 16'h0100 + 16'(i % 4)
          || beat_l[i] !== (i % 4 == 3)) begin
        failures++;
        $display("FAIL toggle_beat%0d got=%0h/%b exp=%0h/%b", i,
                 beat_d[i], beat_l[i], 16'h0100 + 16'(i % 4), (i % 4 == 3));
      end
    end
    step();
  endtask

  task automatic test_stall();
    clear_log();
    repeat_count = 8'd2;
    data_out_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    checks++;
    if (addr_changes != 4 || rom_addr !== 3'd0) begin
      failures++;
      $display("FAIL stall_reads got=%0d/%0h exp=4/0",
               addr_changes, rom_addr);
    end
    checks++;
    if (data_out_valid !== 1'b1 || data_out !== 16'h0100
        || busy !== 1'b1 || beat_d.size() != 0) begin
      failures++;
      $display("FAIL stall_out got=%b/%0h/%b/%0d exp=1/100/1/0",
               data_out_valid, data_out, busy, beat_d.size());
    end
    data_out_ready = 1'b1;
    wait_done(60);
    checks++;
    if (done_cnt != 1 || beat_d.size() != 8) begin
      failures++;
      $display("FAIL stall_count got=%0d/%0d exp=1/8",
               done_cnt, beat_d.size());
    end
    for (int i = 0; i < beat_d.size(); i++) begin
      checks++;
      if (beat_d[i] !== 16'h0100 + 16'(i % 4)) begin
        failures++;
        $display("FAIL stall_beat%0d got=%0h exp=%0h", i,
                 beat_d[i], 16'h0100 + 16'(i % 4));
      end
    end
    step();
  endtask

  task automatic test_zero();
    clear_log();
    repeat_count = 8'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || data_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_done got=%b/%b/%b exp=1/0/0",
               done, busy, data_out_valid);
    end
    repeat (3) step();
    checks++;
    if (done !== 1'b0 || data_out_valid !== 1'b0
        || addr_changes != 0 || done_cnt != 1) begin
      failures++;
      $display("FAIL zero_after got=%b/%b/%0d/%0d exp=0/0/0/1",
               done, data_out_valid, addr_changes, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_log();
    repeat_count = 8'd2;
    data_out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    while (beat_d.size() < 3 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (beat_d.size() != 3) begin
      failures++;
      $display("FAIL mid_pre got=%0d exp=3", beat_d.size());
    end
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rom_addr !== '0
        || data_out_valid !== 1'b0 || data_out_last !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got=%b%b%0h%b%b exp=00000",
               busy, done, rom_addr, data_out_valid, data_out_last);
    end
    rst = 1'b1;
    clear_log();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || rom_addr !== 3'd0) begin
      failures++;
      $display("FAIL mid_restart got=%b/%0h exp=1/0", busy, rom_addr);
    end
    wait_done(60);
    checks++;
    if (done_cnt != 1 || beat_d.size() != 8) begin
      failures++;
      $display("FAIL mid_count got=%0d/%0d exp=1/8",
               done_cnt, beat_d.size());
    end
    if (beat_d.size() > 0) begin
      checks++;
      if (beat_d[0] !== 16'h0100) begin
        failures++;
        $display("FAIL mid_first got=%0h exp=100", beat_d[0]);
      end
    end
    step();
  endtask

  task automatic test_ignore_start();
    clear_log();
    repeat_count = 8'd1;
    data_out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    repeat_count = 8'd3;
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    wait_done(60);
    repeat (3) step();
    checks++;
    if (done_cnt != 1 || beat_d.size() != 4 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_start got=%0d/%0d/%b exp=1/4/0",
               done_cnt, beat_d.size(), busy);
    end
    for (int i = 0; i < beat_d.size(); i++) begin
      checks++;
      if (beat_d[i] !== 16'h0100 + 16'(i) || beat_l[i] !== (i == 3)) begin
        failures++;
        $display("FAIL ignore_beat%0d got=%0h/%b exp=%0h/%b", i,
                 beat_d[i], beat_l[i], 16'h0100 + 16'(i), (i == 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_stall();
    test_zero();
    test_reset_mid();
    test_ignore_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
